pipe_mux_skid: RTL

- Parametrised successor to the fixed 2:1/3:1 datapath muxes used between pipeline stages.
- Selects one of INPUTS data words and registers it into a 2-entry skid buffer with a valid/ready handshake and flush.
- Sits on stage boundaries (e.g. ID/EX operand select) so back-pressure from a stalled stage never drops or duplicates a word.
- Provides a selectable sign/zero extension mode for narrow immediates.

---
 rtl/pipe_mux_skid.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipe_mux_skid.sv
// pipe_mux_skid: INPUTS:1 word mux with optional sign/zero extension, feeding a
// 2-entry skid buffer (main + skid) with valid/ready handshake and flush.
// Optional build macro PIPE_MUX_SKID_STATS_EN adds beat_count / stall_count outputs.
module pipe_mux_skid #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned INPUTS = 3,
  parameter int unsigned EXT_W  = 16,
  localparam int unsigned SEL_W = $clog2(INPUTS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        sel,
  input  logic [1:0]              ext_mode,
  input  logic [INPUTS*WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef PIPE_MUX_SKID_STATS_EN
  ,
  output logic [31:0]             beat_count,
  output logic [31:0]             stall_count
`endif
);

  logic [WIDTH-1:0] mux_word;
  logic [WIDTH-1:0] ext_word;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic             accept;
  logic             rel;

  // Input select; out-of-range select yields an all-zero word.
  always_comb begin
    mux_word = '0;
    for (int unsigned k = 0; k < INPUTS; k++) begin
      if (sel == SEL_W'(k)) mux_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  if (EXT_W < WIDTH) begin : g_ext
    // Widen the low EXT_W bits by sign or zero fill; modes 0 and 3 pass through.
    always_comb begin
      ext_word = mux_word;
      case (ext_mode)
        2'd1:    ext_word = {{(WIDTH-EXT_W){mux_word[EXT_W-1]}}, mux_word[EXT_W-1:0]};
        2'd2:    ext_word = {{(WIDTH-EXT_W){1'b0}}, mux_word[EXT_W-1:0]};
        default: ext_word = mux_word;
      endcase
    end
  end else begin : g_no_ext
    // Field fills the whole word, so every mode is a pass-through.
    logic unused_ext_mode;
    assign unused_ext_mode = ^ext_mode;
    assign ext_word        = mux_word;
  end

  // in_ready depends only on registered skid state, never on out_ready.
  assign in_ready  = !skid_vld_q;
  assign accept    = in_valid && in_ready && !flush;
  assign rel       = main_vld_q && out_ready;
  assign out_data  = main_q;
  assign out_valid = main_vld_q;

  // Next-state of the two-entry buffer; flush clears both valids last.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (skid_vld_q) begin
      if (rel) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (!main_vld_q || rel) begin
      main_vld_d = accept;
      if (accept) main_d = ext_word;
    end else if (accept) begin
      skid_d     = ext_word;
      skid_vld_d = 1'b1;
    end
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end
  end

  // Buffer state register; reset clears data as well as valids.
  always_ff @(posedge clock) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

`ifdef PIPE_MUX_SKID_STATS_EN
  logic [31:0] beat_q, stall_q;

  // Handshake and stall counters; cleared by reset only, wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      if (rel)                       beat_q  <= beat_q + 32'd1;
      if (main_vld_q && !out_ready)  stall_q <= stall_q + 32'd1;
    end
  end

  assign beat_count  = beat_q;
  assign stall_count = stall_q;
`endif

endmodule
